// File: rtl/irrigation_scheduler_if.sv
// Sensor-side inputs and valve-side outputs of the irrigation scheduler.
// The scheduler attaches as slave; the conditioning/driver side as master.
interface irrigation_scheduler_if #(
    parameter int ZONES = 4,
    parameter int ZW    = 2
);
    logic             enable;
    logic [ZONES-1:0] zone_dry;
    logic             water_sensor_conflicting;
    logic             water_available;
    logic [ZONES-1:0] valve;
    logic             pump;
    logic [ZW-1:0]    active_zone;
    logic             busy;
    logic             fault;
    logic             timeout;

    modport master (
        output enable, zone_dry, water_sensor_conflicting, water_available,
        input  valve, pump, active_zone, busy, fault, timeout
    );

    modport slave (
        input  enable, zone_dry, water_sensor_conflicting, water_available,
        output valve, pump, active_zone, busy, fault, timeout
    );
endinterface

// File: rtl/irrigation_scheduler.sv
// Multi-zone irrigation scheduler: debounced dry sensors, round-robin
// single-valve drive with maximum run time and mandatory rest.
module irrigation_scheduler #(
    parameter int ZONES    = 4,
    parameter int DEBOUNCE = 4,
    parameter int MAX_ON   = 16,
    parameter int REST     = 4,
    parameter int ZW       = 2
) (
    input logic                  clock,
    input logic                  reset,
    irrigation_scheduler_if.slave bus
);
    localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int RW = $clog2(MAX_ON);
    localparam int TW = (REST > 1) ? $clog2(REST) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        RESTING
    } state_t;

    state_t           state, state_n;
    logic [ZONES-1:0] dry_f;
    logic [DW-1:0]    db_cnt [ZONES];
    logic [ZONES-1:0] valve, valve_n;
    logic             pump;
    logic [ZW-1:0]    zone, zone_n, sel;
    logic [RW-1:0]    run_cnt, run_n;
    logic [TW-1:0]    rest_cnt, rest_n;
    logic             fault;
    logic             timeout, timeout_n;
    logic             permit;
    logic             last;

    // A raw bit must disagree for DEBOUNCE consecutive samples to be taken.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dry_f <= '0;
            for (int i = 0; i < ZONES; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < ZONES; i++) begin
                if (bus.zone_dry[i] == dry_f[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DW'(DEBOUNCE - 1)) begin
                    dry_f[i]  <= bus.zone_dry[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign permit = bus.enable & ~fault;
    assign last   = (run_cnt == RW'(MAX_ON - 1));

    // Later assignments win, so scan from farthest to nearest successor.
    always_comb begin
        int idx;
        idx = 0;
        sel = zone;
        for (int i = ZONES; i >= 1; i--) begin
            idx = (int'(zone) + i) % ZONES;
            if (dry_f[idx[ZW-1:0]]) sel = idx[ZW-1:0];
        end
    end

    always_comb begin
        state_n   = state;
        valve_n   = valve;
        zone_n    = zone;
        run_n     = run_cnt;
        rest_n    = rest_cnt;
        timeout_n = 1'b0;
        case (state)
            IDLE: begin
                valve_n = '0;
                if (permit && |dry_f) begin
                    state_n = RUN;
                    valve_n = ZONES'(1) << sel;
                    zone_n  = sel;
                    run_n   = '0;
                end
            end
            RUN: begin
                if (!permit || !dry_f[zone] || last) begin
                    state_n   = RESTING;
                    valve_n   = '0;
                    rest_n    = '0;
                    timeout_n = permit & dry_f[zone] & last;
                end else begin
                    run_n = run_cnt + 1'b1;
                end
            end
            RESTING: begin
                valve_n = '0;
                if (rest_cnt == TW'(REST - 1)) state_n = IDLE;
                else rest_n = rest_cnt + 1'b1;
            end
            default: begin
                state_n = IDLE;
                valve_n = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            valve    <= '0;
            pump     <= 1'b0;
            zone     <= ZW'(ZONES - 1);
            run_cnt  <= '0;
            rest_cnt <= '0;
            fault    <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_n;
            valve    <= valve_n;
            pump     <= |valve_n;
            zone     <= zone_n;
            run_cnt  <= run_n;
            rest_cnt <= rest_n;
            fault    <= bus.water_sensor_conflicting | ~bus.water_available;
            timeout  <= timeout_n;
        end
    end

    assign bus.valve       = valve;
    assign bus.pump        = pump;
    assign bus.active_zone = zone;
    assign bus.busy        = (state != IDLE);
    assign bus.fault       = fault;
    assign bus.timeout     = timeout;
endmodule

// File: tb/tb_irrigation_scheduler.sv
// Scoreboard bench: stimulus queues expected runs, a monitor
// reassembles each observed run plus its rest and compares.
module tb_irrigation_scheduler;
    localparam int ZONES = 4;
    localparam int ZW    = 2;

    typedef struct {
        int zone;
        int on;
        int to;
        int rest;
    } rec_t;

    logic clock;
    logic reset;
    int   checks;
    int   errors;
    rec_t exp_q[$];

    irrigation_scheduler_if #(.ZONES(ZONES), .ZW(ZW)) ifc ();

    irrigation_scheduler #(
        .ZONES(ZONES), .DEBOUNCE(4), .MAX_ON(16), .REST(4), .ZW(ZW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (ifc.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic push(input int z, input int on, input int to, input int rs);
        rec_t r;
        r.zone = z;
        r.on   = on;
        r.to   = to;
        r.rest = rs;
        exp_q.push_back(r);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending %0d expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_reset(input logic [ZONES-1:0] dry);
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        ifc.zone_dry = dry;
        ifc.enable = 1'b1;
        ifc.water_available = 1'b1;
        ifc.water_sensor_conflicting = 1'b0;
    endtask

    task automatic wait_valve();
        int n;
        n = 0;
        while (ifc.valve == '0 && n < 40) begin
            @(negedge clock);
            n++;
        end
        chk("valve_start", int'(ifc.valve != '0), 1);
    endtask

    // Monitor: one record per run, closed when the rest period ends.
    initial begin
        bit   in_run, in_rest;
        int   cz, con, cto, crest;
        rec_t e;
        in_run = 0;
        in_rest = 0;
        cz = 0; con = 0; cto = 0; crest = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                in_run = 0;
                in_rest = 0;
            end else begin
                checks++;
                if (!$onehot0(ifc.valve) || ifc.pump != (ifc.valve != '0)) begin
                    errors++;
                    $display("FAIL valve_pump valve=%b pump=%b need onehot0 and pump=|valve",
                             ifc.valve, ifc.pump);
                end
                if (ifc.valve != '0) begin
                    if (!in_run) begin
                        in_run = 1;
                        in_rest = 0;
                        con = 1;
                        for (int k = 0; k < ZONES; k++)
                            if (ifc.valve[k]) cz = k;
                    end else begin
                        con++;
                    end
                end else if (in_run) begin
                    in_run = 0;
                    in_rest = 1;
                    crest = int'(ifc.busy);
                    cto = int'(ifc.timeout);
                end else if (in_rest) begin
                    if (ifc.busy) begin
                        crest++;
                        cto += int'(ifc.timeout);
                    end else begin
                        in_rest = 0;
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_run zone=%0d on=%0d to=%0d rest=%0d expected none",
                                     cz, con, cto, crest);
                        end else begin
                            e = exp_q.pop_front();
                            if (e.zone != cz || e.on != con || e.to != cto || e.rest != crest) begin
                                errors++;
                                $display("FAIL run_record got z=%0d on=%0d to=%0d rest=%0d expected z=%0d on=%0d to=%0d rest=%0d",
                                         cz, con, cto, crest, e.zone, e.on, e.to, e.rest);
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        ifc.enable = 1'b0;
        ifc.zone_dry = '0;
        ifc.water_available = 1'b1;
        ifc.water_sensor_conflicting = 1'b0;

        // Reset state, then first-selection latency on zone 2
        do_reset(4'b0100);
        chk("rst_valve", int'(ifc.valve), 0);
        chk("rst_pump", int'(ifc.pump), 0);
        chk("rst_active_zone", int'(ifc.active_zone), 3);
        chk("rst_busy", int'(ifc.busy), 0);
        chk("rst_fault", int'(ifc.fault), 0);
        chk("rst_timeout", int'(ifc.timeout), 0);
        push(2, 16, 1, 4);
        push(2, 16, 1, 4);
        repeat (4) @(negedge clock);
        chk("latency_valve_low", int'(ifc.valve), 0);
        @(negedge clock);
        chk("first_valve", int'(ifc.valve), 4);
        chk("first_pump", int'(ifc.pump), 1);
        chk("first_zone", int'(ifc.active_zone), 2);
        chk("first_busy", int'(ifc.busy), 1);
        drain(200);

        // Round robin over zones 0,1,3
        do_reset(4'b1011);
        push(0, 16, 1, 4);
        push(1, 16, 1, 4);
        push(3, 16, 1, 4);
        push(0, 16, 1, 4);
        push(1, 16, 1, 4);
        drain(400);

        // 3-cycle glitch filtered out, 4-cycle pulse served
        do_reset(4'b0010);
        repeat (3) @(negedge clock);
        ifc.zone_dry = 4'b0000;
        repeat (20) @(negedge clock);
        chk("glitch_valve", int'(ifc.valve), 0);
        chk("glitch_busy", int'(ifc.busy), 0);
        push(1, 4, 0, 4);
        ifc.zone_dry = 4'b0010;
        repeat (4) @(negedge clock);
        ifc.zone_dry = 4'b0000;
        drain(100);

        // Sensor conflict aborts zone 0 without timeout
        do_reset(4'b0001);
        push(0, 7, 0, 4);
        wait_valve();
        repeat (5) @(negedge clock);
        ifc.water_sensor_conflicting = 1'b1;
        @(negedge clock);
        chk("conflict_fault", int'(ifc.fault), 1);
        chk("conflict_valve_held", int'(ifc.valve), 1);
        @(negedge clock);
        chk("abort_valve", int'(ifc.valve), 0);
        chk("abort_timeout", int'(ifc.timeout), 0);
        drain(50);
        repeat (20) @(negedge clock);
        chk("fault_no_restart", int'(ifc.valve), 0);
        push(0, 16, 1, 4);
        ifc.water_sensor_conflicting = 1'b0;
        drain(100);

        // Asynchronous reset mid-run
        do_reset(4'b0011);
        wait_valve();
        repeat (3) @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        chk("async_valve", int'(ifc.valve), 0);
        chk("async_pump", int'(ifc.pump), 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        chk("async_active_zone", int'(ifc.active_zone), 3);
        push(0, 16, 1, 4);
        drain(100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
